// File: rtl/mem_pkg.sv
// Shared definitions for the sized data memory: access-size encodings,
// controller state type and the alignment check.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE   = 2'd0;
  localparam logic [1:0] SZ_HALF   = 2'd1;
  localparam logic [1:0] SZ_WORD   = 2'd2;
  localparam logic [1:0] SZ_DOUBLE = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } memStateT;

  // An access is aligned when the address is a multiple of its byte count.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [2:0] addrLow);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addrLow[0];
      SZ_WORD: return |addrLow[1:0];
      default: return |addrLow;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational byte-lane logic: merges store data into a memory word and
// extracts/extends the addressed lanes for the response.
module dmem_lane_unit
  import mem_pkg::*;
#(
  parameter int DATA_BITS = 64,
  parameter int LANE_BITS = $clog2(DATA_BITS / 8)
) (
  input  logic [1:0]           size,
  input  logic                 isUnsigned,
  input  logic                 isWrite,
  input  logic [LANE_BITS-1:0] offset,
  input  logic [DATA_BITS-1:0] rdWord,
  input  logic [DATA_BITS-1:0] wData,
  output logic [DATA_BITS-1:0] newWord,
  output logic [DATA_BITS-1:0] rspData
);

  localparam int IDX_BITS = LANE_BITS + 3;

  logic [DATA_BITS-1:0] fieldMask;
  logic [DATA_BITS-1:0] laneMask;
  logic [DATA_BITS-1:0] srcWord;
  logic [DATA_BITS-1:0] shifted;
  logic [IDX_BITS-1:0]  shamt;
  logic [IDX_BITS-1:0]  signIdx;
  logic                 signFill;

  // A full-width access uses the all-ones mask, so extension becomes a no-op.
  always_comb begin
    fieldMask = '1;
    signIdx   = IDX_BITS'(DATA_BITS - 1);
    case (size)
      SZ_BYTE: begin
        fieldMask = DATA_BITS'(8'hFF);
        signIdx   = IDX_BITS'(7);
      end
      SZ_HALF: begin
        fieldMask = DATA_BITS'(16'hFFFF);
        signIdx   = IDX_BITS'(15);
      end
      SZ_WORD: begin
        fieldMask = DATA_BITS'(32'hFFFF_FFFF);
        signIdx   = IDX_BITS'(31);
      end
      default: ;
    endcase

    shamt    = {offset, 3'b000};
    laneMask = fieldMask << shamt;
    newWord  = (rdWord & ~laneMask) | ((wData << shamt) & laneMask);

    // Stores report the lanes exactly as a following load would see them.
    srcWord  = isWrite ? newWord : rdWord;
    shifted  = srcWord >> shamt;
    signFill = !isUnsigned && shifted[signIdx];
    rspData  = (shifted & fieldMask) | (signFill ? ~fieldMask : '0);
  end

endmodule

// File: rtl/sized_data_mem.sv
// Data memory with byte/half/word/double accesses, fixed wait states and a
// valid/ready request/response handshake.
module sized_data_mem
  import mem_pkg::*;
#(
  parameter int DATA_BITS   = 64,
  parameter int ADDR_BITS   = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 reqValid,
  output logic                 reqReady,
  input  logic                 reqWrite,
  input  logic [1:0]           reqSize,
  input  logic                 reqUnsigned,
  input  logic [ADDR_BITS-1:0] reqAddr,
  input  logic [DATA_BITS-1:0] reqWData,
  output logic                 rspValid,
  input  logic                 rspReady,
  output logic [DATA_BITS-1:0] rspData,
  output logic                 rspError
);

  localparam int BYTES      = DATA_BITS / 8;
  localparam int LANE_BITS  = $clog2(BYTES);
  localparam int INDEX_BITS = ADDR_BITS - LANE_BITS;
  localparam int DEPTH      = 2 ** INDEX_BITS;
  localparam logic [3:0] LAST_WAIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [DATA_BITS-1:0] mem [DEPTH];

  memStateT state, nextState;
  logic [3:0] waitCnt, waitCntNext;

  logic                 writeQ, unsignedQ;
  logic [1:0]           sizeQ;
  logic [ADDR_BITS-1:0] addrQ;
  logic [DATA_BITS-1:0] wDataQ;

  logic                 actWrite, actUnsigned;
  logic [1:0]           actSize;
  logic [ADDR_BITS-1:0] actAddr;
  logic [DATA_BITS-1:0] actWData;

  logic                  reqError, enterResp, respErr, commit;
  logic [INDEX_BITS-1:0] wordIdx;
  logic [LANE_BITS-1:0]  offset;
  logic [DATA_BITS-1:0]  rdWord, newWord, laneData, rspDataQ;
  logic                  rspErrorQ;

  assign reqReady = (state == IDLE);
  assign rspValid = (state == RESP);
  assign rspData  = rspDataQ;
  assign rspError = rspErrorQ;

  assign reqError = isMisaligned(reqSize, reqAddr[2:0]) ||
                    (reqSize == SZ_DOUBLE && DATA_BITS == 32);

  // In IDLE the live request drives the datapath so zero-wait accesses and
  // errors can finish on the accept edge; afterwards the latched copy is used.
  always_comb begin
    if (state == IDLE) begin
      actWrite    = reqWrite;
      actUnsigned = reqUnsigned;
      actSize     = reqSize;
      actAddr     = reqAddr;
      actWData    = reqWData;
    end else begin
      actWrite    = writeQ;
      actUnsigned = unsignedQ;
      actSize     = sizeQ;
      actAddr     = addrQ;
      actWData    = wDataQ;
    end
  end

  assign wordIdx = actAddr[ADDR_BITS-1:LANE_BITS];
  assign offset  = actAddr[LANE_BITS-1:0];
  assign rdWord  = mem[wordIdx];

  dmem_lane_unit #(
    .DATA_BITS(DATA_BITS),
    .LANE_BITS(LANE_BITS)
  ) laneUnit (
    .size      (actSize),
    .isUnsigned(actUnsigned),
    .isWrite   (actWrite),
    .offset    (offset),
    .rdWord    (rdWord),
    .wData     (actWData),
    .newWord   (newWord),
    .rspData   (laneData)
  );

  always_comb begin
    nextState   = state;
    waitCntNext = waitCnt;
    enterResp   = 1'b0;
    respErr     = 1'b0;
    case (state)
      IDLE: begin
        if (reqValid) begin
          waitCntNext = '0;
          if (reqError) begin
            nextState = RESP;
            enterResp = 1'b1;
            respErr   = 1'b1;
          end else if (WAIT_CYCLES == 0) begin
            nextState = RESP;
            enterResp = 1'b1;
          end else begin
            nextState = WAIT;
          end
        end
      end
      WAIT: begin
        if (waitCnt == LAST_WAIT) begin
          nextState = RESP;
          enterResp = 1'b1;
        end else begin
          waitCntNext = waitCnt + 4'd1;
        end
      end
      RESP: begin
        if (rspReady) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  assign commit = enterResp && !respErr && actWrite && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      waitCnt   <= '0;
      rspDataQ  <= '0;
      rspErrorQ <= 1'b0;
    end else begin
      state   <= nextState;
      waitCnt <= waitCntNext;
      if (enterResp) begin
        rspDataQ  <= respErr ? '0 : laneData;
        rspErrorQ <= respErr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      writeQ    <= 1'b0;
      unsignedQ <= 1'b0;
      sizeQ     <= SZ_BYTE;
      addrQ     <= '0;
      wDataQ    <= '0;
    end else if (reqValid && state == IDLE) begin
      writeQ    <= reqWrite;
      unsignedQ <= reqUnsigned;
      sizeQ     <= reqSize;
      addrQ     <= reqAddr;
      wDataQ    <= reqWData;
    end
  end

  // Array contents survive reset; only the edge entering RESP may write.
  always_ff @(posedge clk) begin
    if (commit) mem[wordIdx] <= newWord;
  end

endmodule

// File: tb/tb_sized_data_mem.sv
// Scoreboard bench: a 64-bit two-wait-state memory plus a zero-wait build
// driven back to back with rspReady tied high.
module tb_sized_data_mem;
  import mem_pkg::*;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          lat;
    int          stall;
    int          issue;
  } expT;

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [11:0] a;
    logic [63:0] wd;
    logic [63:0] d;
  } vecT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        reqValid = 1'b0, reqWrite = 1'b0, reqUnsigned = 1'b0;
  logic [1:0]  reqSize = 2'd0;
  logic [11:0] reqAddr = '0;
  logic [63:0] reqWData = '0;
  logic        reqReady, rspValid, rspError;
  logic        rspReady = 1'b0;
  logic [63:0] rspData;

  logic        reqValidB = 1'b0, reqWriteB = 1'b0, reqUnsignedB = 1'b0;
  logic [1:0]  reqSizeB = 2'd0;
  logic [11:0] reqAddrB = '0;
  logic [63:0] reqWDataB = '0;
  logic        reqReadyB, rspValidB, rspErrorB;
  logic [63:0] rspDataB;

  int  testsRun = 0;
  int  testsFailed = 0;
  int  cycle = 0;
  expT expQ[$];
  expT expQB[$];
  expT cur;
  expT curB;
  logic monBusy = 1'b0;
  int  stallLeft = 0;
  int  lastSeenB = -1;
  vecT vecB[6];

  sized_data_mem #(.DATA_BITS(64), .ADDR_BITS(12), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqSize(reqSize), .reqUnsigned(reqUnsigned), .reqAddr(reqAddr),
    .reqWData(reqWData), .rspValid(rspValid), .rspReady(rspReady),
    .rspData(rspData), .rspError(rspError)
  );

  sized_data_mem #(.DATA_BITS(64), .ADDR_BITS(12), .WAIT_CYCLES(0)) dutZero (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValidB), .reqReady(reqReadyB), .reqWrite(reqWriteB),
    .reqSize(reqSizeB), .reqUnsigned(reqUnsignedB), .reqAddr(reqAddrB),
    .reqWData(reqWDataB), .rspValid(rspValidB), .rspReady(1'b1),
    .rspData(rspDataB), .rspError(rspErrorB)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic reportTimeout(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s: timed out", name);
  endtask

  task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic u,
                               input logic [11:0] a, input logic [63:0] wd,
                               input logic [63:0] expData, input logic expErr,
                               input int stall, input logic expectRsp);
    int g;
    g = 0;
    @(negedge clk);
    while (reqReady !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (reqReady !== 1'b1) begin
      reportTimeout("reqReady wait");
      return;
    end
    reqWrite = w; reqSize = sz; reqUnsigned = u; reqAddr = a; reqWData = wd;
    reqValid = 1'b1;
    if (expectRsp) expQ.push_back('{expData, expErr, expErr ? 1 : 3, stall, cycle});
    @(negedge clk);
    reqValid = 1'b0;
  endtask

  task automatic waitDone();
    int g;
    g = 0;
    while ((expQ.size() != 0 || monBusy) && g < 60) begin
      @(negedge clk);
      g++;
    end
    if (expQ.size() != 0 || monBusy) reportTimeout("response drain");
    @(negedge clk);
  endtask

  // Monitor for the wait-state DUT; it also owns rspReady to create stalls.
  always @(negedge clk) begin
    if (rspValid === 1'b1) begin
      if (!monBusy) begin
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected response: got data 0x%016h, expected none", rspData);
          rspReady = 1'b1;
        end else begin
          cur = expQ.pop_front();
          monBusy = 1'b1;
          stallLeft = cur.stall;
          checkOutput("latency", 64'(cycle - cur.issue), 64'(cur.lat));
          checkOutput("rspData", rspData, cur.data);
          checkOutput("rspError", 64'(rspError), 64'(cur.err));
        end
      end else begin
        checkOutput("stall rspData", rspData, cur.data);
        checkOutput("stall reqReady", 64'(reqReady), 64'd0);
      end
      if (monBusy) begin
        if (stallLeft == 0) begin
          rspReady = 1'b1;
          monBusy = 1'b0;
        end else begin
          rspReady = 1'b0;
          stallLeft--;
        end
      end
    end else begin
      rspReady = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rspValidB === 1'b1) begin
      if (expQB.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL zero-wait unexpected response: got 0x%016h, expected none", rspDataB);
      end else begin
        curB = expQB.pop_front();
        checkOutput("zero-wait latency", 64'(cycle - curB.issue), 64'(curB.lat));
        checkOutput("zero-wait rspData", rspDataB, curB.data);
        checkOutput("zero-wait rspError", 64'(rspErrorB), 64'(curB.err));
        if (lastSeenB >= 0) checkOutput("zero-wait period", 64'(cycle - lastSeenB), 64'd2);
        lastSeenB = cycle;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int g;
    repeat (3) @(negedge clk);
    checkOutput("reset reqReady", 64'(reqReady), 64'd1);
    checkOutput("reset rspValid", 64'(rspValid), 64'd0);
    checkOutput("reset rspData", rspData, 64'd0);
    checkOutput("reset rspError", 64'(rspError), 64'd0);
    rst_n = 1'b1;

    applyStimulus(1, SZ_DOUBLE, 0, 12'h008, 64'h0011223344556677, 64'h0011223344556677, 0, 0, 1);
    applyStimulus(0, SZ_DOUBLE, 0, 12'h008, 64'h0, 64'h0011223344556677, 0, 0, 1);
    applyStimulus(1, SZ_BYTE, 0, 12'h00B, 64'h80, 64'hFFFFFFFFFFFFFF80, 0, 0, 1);
    applyStimulus(0, SZ_BYTE, 0, 12'h00B, 64'h0, 64'hFFFFFFFFFFFFFF80, 0, 0, 1);
    applyStimulus(0, SZ_BYTE, 1, 12'h00B, 64'h0, 64'h0000000000000080, 0, 0, 1);
    applyStimulus(0, SZ_DOUBLE, 0, 12'h008, 64'h0, 64'h0011223380556677, 0, 0, 1);
    applyStimulus(0, SZ_WORD, 0, 12'h00A, 64'h0, 64'h0, 1, 0, 1);
    applyStimulus(1, SZ_DOUBLE, 0, 12'h00C, 64'hDEADBEEFDEADBEEF, 64'h0, 1, 0, 1);
    applyStimulus(0, SZ_HALF, 1, 12'h009, 64'h0, 64'h0, 1, 0, 1);
    applyStimulus(0, SZ_DOUBLE, 0, 12'h008, 64'h0, 64'h0011223380556677, 0, 0, 1);
    applyStimulus(1, SZ_HALF, 0, 12'h010, 64'hBEEF, 64'hFFFFFFFFFFFFBEEF, 0, 0, 1);
    applyStimulus(0, SZ_HALF, 1, 12'h010, 64'h0, 64'h000000000000BEEF, 0, 4, 1);
    applyStimulus(1, SZ_WORD, 1, 12'h014, 64'h89ABCDEF, 64'h0000000089ABCDEF, 0, 0, 1);
    applyStimulus(0, SZ_WORD, 0, 12'h014, 64'h0, 64'hFFFFFFFF89ABCDEF, 0, 0, 1);
    applyStimulus(0, SZ_WORD, 0, 12'h00C, 64'h0, 64'h0000000000112233, 0, 0, 1);
    waitDone();

    // Reset while a store sits in WAIT must drop it without touching the array.
    applyStimulus(1, SZ_DOUBLE, 0, 12'h008, 64'hFFFFFFFFFFFFFFFF, 64'h0, 0, 0, 0);
    checkOutput("in WAIT reqReady", 64'(reqReady), 64'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset reqReady", 64'(reqReady), 64'd1);
    checkOutput("async reset rspValid", 64'(rspValid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("after reset reqReady", 64'(reqReady), 64'd1);
    checkOutput("after reset rspValid", 64'(rspValid), 64'd0);
    applyStimulus(0, SZ_DOUBLE, 0, 12'h008, 64'h0, 64'h0011223380556677, 0, 0, 1);
    waitDone();

    vecB[0] = '{1'b1, SZ_DOUBLE, 1'b0, 12'h000, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF};
    vecB[1] = '{1'b1, SZ_DOUBLE, 1'b0, 12'h008, 64'hFEDCBA9876543210, 64'hFEDCBA9876543210};
    vecB[2] = '{1'b0, SZ_DOUBLE, 1'b0, 12'h000, 64'h0, 64'h0123456789ABCDEF};
    vecB[3] = '{1'b0, SZ_DOUBLE, 1'b0, 12'h008, 64'h0, 64'hFEDCBA9876543210};
    vecB[4] = '{1'b0, SZ_BYTE, 1'b0, 12'h00F, 64'h0, 64'hFFFFFFFFFFFFFFFE};
    vecB[5] = '{1'b0, SZ_HALF, 1'b1, 12'h00E, 64'h0, 64'h000000000000FEDC};
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      g = 0;
      reqWriteB = vecB[i].w; reqSizeB = vecB[i].sz; reqUnsignedB = vecB[i].u;
      reqAddrB = vecB[i].a; reqWDataB = vecB[i].wd;
      reqValidB = 1'b1;
      while (reqReadyB !== 1'b1 && g < 20) begin
        @(negedge clk);
        g++;
      end
      if (reqReadyB !== 1'b1) begin
        reportTimeout("zero-wait reqReady wait");
        break;
      end
      expQB.push_back('{vecB[i].d, 1'b0, 1, 0, cycle});
      @(negedge clk);
    end
    reqValidB = 1'b0;
    g = 0;
    while (expQB.size() != 0 && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (expQB.size() != 0) reportTimeout("zero-wait drain");
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
